// File: rtl/led_trail_fader.sv
// LED output stage: lit LEDs drive solid, LEDs that go dark fade out through PWM levels.
// Registered path: frame_in -> frame_q -> led_out (2 clk); no backpressure, one frame per clk.
module led_trail_fader #(
  parameter int N_LED       = 16,
  parameter int PWM_BITS    = 4,
  parameter int DECAY_TICKS = 1500000,
  parameter int DECAY_STEP  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_LED-1:0] frame_in,
  input  logic             fade_en,
  output logic [N_LED-1:0] led_out,
  output logic             busy
);

  localparam int CNT_W = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DECAY_TICKS - 1);
  localparam logic [PWM_BITS-1:0] MAX_LVL  = '1;
  localparam logic [PWM_BITS-1:0] STEP     = PWM_BITS'(DECAY_STEP);

  logic [N_LED-1:0]    frame_q;
  logic [CNT_W-1:0]    decay_cnt;
  logic                tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] bright     [N_LED];
  logic [PWM_BITS-1:0] bright_nxt [N_LED];
  logic [N_LED-1:0]    glow;
  logic [N_LED-1:0]    lingering;

  assign tick = (decay_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q   <= '0;
      decay_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      frame_q   <= frame_in;
      decay_cnt <= tick ? '0 : decay_cnt + 1'b1;
      pwm_cnt   <= pwm_cnt + 1'b1;
    end
  end

  // Relight beats decay; decay saturates at zero instead of wrapping.
  always_comb begin
    for (int i = 0; i < N_LED; i++) begin
      bright_nxt[i] = bright[i];
      if (!fade_en) begin
        bright_nxt[i] = '0;
      end else if (frame_q[i]) begin
        bright_nxt[i] = MAX_LVL;
      end else if (tick) begin
        bright_nxt[i] = (bright[i] > STEP) ? bright[i] - STEP : '0;
      end
    end
  end

  always_comb begin
    glow      = '0;
    lingering = '0;
    for (int i = 0; i < N_LED; i++) begin
      glow[i]      = fade_en & (bright[i] > pwm_cnt);
      lingering[i] = (bright[i] != '0) & ~frame_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_LED; i++) begin
        bright[i] <= '0;
      end
      led_out <= '0;
      busy    <= 1'b0;
    end else begin
      for (int i = 0; i < N_LED; i++) begin
        bright[i] <= bright_nxt[i];
      end
      led_out <= frame_q | glow;
      busy    <= fade_en & (|lingering);
    end
  end

endmodule

// File: tb/tb_led_trail_fader.sv
// Bench for led_trail_fader: two instances (decay step 2 and 4) against a per-LED brightness model.
module tb_led_trail_fader;

  localparam int TICKS = 4;
  localparam int MAXV  = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] frame_in = 16'hFFFF;
  logic        fade_en  = 1'b1;
  logic [15:0] led_out, led_sat;
  logic        busy, busy_sat;

  int errors = 0;
  int checks = 0;

  // Reference state: shared counters, per-instance brightness as plain integers.
  int          steps [2] = '{2, 4};
  int          m_br  [2][16];
  logic [15:0] m_fq;
  int          m_cnt;
  int          m_pwm;
  logic [15:0] m_led [2];
  logic        m_busy[2];

  led_trail_fader #(.N_LED(16), .PWM_BITS(4), .DECAY_TICKS(TICKS), .DECAY_STEP(2)) u_dut (
    .clk(clk), .rst(rst), .frame_in(frame_in), .fade_en(fade_en),
    .led_out(led_out), .busy(busy));

  led_trail_fader #(.N_LED(16), .PWM_BITS(4), .DECAY_TICKS(TICKS), .DECAY_STEP(4)) u_sat (
    .clk(clk), .rst(rst), .frame_in(frame_in), .fade_en(fade_en),
    .led_out(led_sat), .busy(busy_sat));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) m_br[d][i] = 0;
      m_led[d]  = '0;
      m_busy[d] = 1'b0;
    end
    m_fq  = '0;
    m_cnt = 0;
    m_pwm = 0;
  endtask

  task automatic model_step(input logic [15:0] f, input logic fe);
    bit tk;
    tk = (m_cnt == TICKS - 1);
    for (int d = 0; d < 2; d++) begin
      logic [15:0] l;
      bit          b;
      l = '0;
      b = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (m_fq[i] || (fe && m_br[d][i] > m_pwm)) l[i] = 1'b1;
        if (fe && m_br[d][i] != 0 && !m_fq[i]) b = 1'b1;
      end
      m_led[d]  = l;
      m_busy[d] = b;
      for (int i = 0; i < 16; i++) begin
        if (!fe)                 m_br[d][i] = 0;
        else if (m_fq[i])        m_br[d][i] = MAXV;
        else if (tk)             m_br[d][i] = (m_br[d][i] > steps[d]) ? m_br[d][i] - steps[d] : 0;
      end
    end
    m_fq  = f;
    m_cnt = (m_cnt + 1) % TICKS;
    m_pwm = (m_pwm + 1) % 16;
  endtask

  task automatic cycle(input logic [15:0] f, input logic fe);
    frame_in = f;
    fade_en  = fe;
    @(posedge clk);
    model_step(f, fe);
    #1;
    check("led_out", led_out, m_led[0]);
    check("busy", busy, m_busy[0]);
    check("sat_led_out", led_sat, m_led[1]);
    check("sat_busy", busy_sat, m_busy[1]);
  endtask

  initial begin
    int q_main[$];
    int q_sat[$];
    int exp_main[9] = '{15, 13, 11, 9, 7, 5, 3, 1, 0};
    int exp_sat[5]  = '{15, 11, 7, 3, 0};
    logic [15:0] walk[4] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
    logic [15:0] stray;
    logic [15:0] f;
    logic        fe;
    int          done_k;
    bit          seen_busy;
    bit          found;

    // Reset held with all LEDs requested on.
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_led_out", led_out, 16'h0000);
      check("rst_busy", busy, 1'b0);
    end
    rst = 1'b1;
    cycle(16'hFFFF, 1'b1);
    check("release_1edge", led_out, 16'h0000);
    cycle(16'hFFFF, 1'b1);
    check("release_2edge", led_out, 16'hFFFF);

    // Clear any trails, then a single-LED trail.
    for (int k = 0; k < 3; k++) cycle(16'h0000, 1'b0);
    q_main.delete();
    q_sat.delete();
    stray = '0;
    for (int k = 0; k < 8; k++) cycle(16'h0001, 1'b1);
    done_k = -1;
    seen_busy = 1'b0;
    for (int k = 0; k < 45; k++) begin
      cycle(16'h0000, 1'b1);
      stray |= led_out & 16'hFFFE;
      if (busy) seen_busy = 1'b1;
      else if (seen_busy && done_k < 0) done_k = k;
      if ((q_main.size() > 0 || u_dut.bright[0] == 4'd15) &&
          (q_main.size() == 0 || q_main[$] != int'(u_dut.bright[0])))
        q_main.push_back(int'(u_dut.bright[0]));
      if ((q_sat.size() > 0 || u_sat.bright[0] == 4'd15) &&
          (q_sat.size() == 0 || q_sat[$] != int'(u_sat.bright[0])))
        q_sat.push_back(int'(u_sat.bright[0]));
    end
    check("trail_stray_bits", stray, 16'h0000);
    check("trail_busy_seen", seen_busy, 1'b1);
    check("trail_len_range", (done_k >= 28 && done_k <= 36), 1'b1);
    check("trail_levels", q_main.size(), 9);
    for (int k = 0; k < 9; k++)
      check("trail_level", (q_main.size() > k) ? q_main[k] : 99, exp_main[k]);
    check("sat_levels", q_sat.size(), 5);
    for (int k = 0; k < 5; k++)
      check("sat_level", (q_sat.size() > k) ? q_sat[k] : 99, exp_sat[k]);

    // Relight at level 7.
    for (int k = 0; k < 4; k++) cycle(16'h0020, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle(16'h0000, 1'b1);
      if (m_br[0][5] == 7) found = 1'b1;
    end
    check("relight_reach7", found, 1'b1);
    cycle(16'h0020, 1'b1);
    cycle(16'h0020, 1'b1);
    check("relight_bright", u_dut.bright[5], 4'd15);
    for (int k = 0; k < 4; k++) begin
      cycle(16'h0020, 1'b1);
      check("relight_solid", led_out[5], 1'b1);
    end

    // Relight landing on a tick cycle.
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle(16'h0000, 1'b1);
      if (m_br[0][5] > 0 && m_br[0][5] < MAXV && m_cnt == TICKS - 2) found = 1'b1;
    end
    check("tick_relight_found", found, 1'b1);
    cycle(16'h0020, 1'b1);
    cycle(16'h0020, 1'b1);
    check("tick_relight_bright", u_dut.bright[5], 4'd15);

    // Pass-through with a walking bit.
    for (int k = 0; k < 4; k++) begin
      cycle(walk[k], 1'b0);
      if (k >= 1) check("walk_follow", led_out, walk[k-1]);
      check("walk_busy", busy, 1'b0);
    end

    // Disable mid-fade.
    for (int k = 0; k < 3; k++) cycle(16'h0F00, 1'b1);
    for (int k = 0; k < 6; k++) cycle(16'h0000, 1'b1);
    check("pre_disable_busy", busy, 1'b1);
    cycle(16'h0000, 1'b0);
    check("disable_busy", busy, 1'b0);
    cycle(16'h0000, 1'b0);
    check("disable_bright", u_dut.bright[8], 4'd0);
    check("disable_led", led_out, 16'h0000);

    // Async reset mid-fade, between clock edges.
    for (int k = 0; k < 3; k++) cycle(16'hA5A5, 1'b1);
    for (int k = 0; k < 3; k++) cycle(16'h0000, 1'b1);
    check("pre_arst_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("arst_led_now", led_out, 16'h0000);
    check("arst_busy_now", busy, 1'b0);
    check("arst_sat_led_now", led_sat, 16'h0000);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cycle(16'h0000, 1'b1);
      check("post_arst_led", led_out, 16'h0000);
    end

    // Randomized frames and fade_en toggling.
    f = '0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) f = 16'($urandom);
      fe = ($urandom_range(0, 15) != 0);
      cycle(f, fe);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
